// File: rtl/tt_pkg.sv
// Shared types and constants for the tic-tac-toe board controller.
package tt_pkg;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WIN  = 2'd1,
        ST_DRAW = 2'd2
    } state_t;

    // Player to move; a placed mark's shape bit is 1 for X (square), 0 for O (plus).
    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_X    = 2'b01;
    localparam logic [1:0] WINNER_O    = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;
    localparam int CELL_W    = 4;

    // Rows 0-2, columns 0-2, main diagonal, anti-diagonal.
    localparam logic [0:7][0:2][CELL_W-1:0] LINES = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // True when every cell of line idx holds a mark with shape bit equal to mark.
    function automatic logic line_complete(input logic [8:0] drawn,
                                           input logic [8:0] shape,
                                           input logic [2:0] idx,
                                           input logic       mark);
        logic r;
        r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            r = r & drawn[LINES[idx][k]] & (shape[LINES[idx][k]] == mark);
        end
        return r;
    endfunction

endpackage

// File: rtl/board_controller_debounce.sv
// Per-button debouncer: accepts a level after it has been stable long enough,
// and emits a single-cycle pulse on each accepted rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;

    // Count consecutive cycles where the raw level differs from the accepted one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_btn == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= i_btn;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Turn an accepted rising edge into a one-cycle press pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/board_controller.sv
// Tic-tac-toe input controller: debounced buttons drive a cursor and an
// X/O game FSM; a registered tiles/color image feeds the tile renderer.
module board_controller
    import tt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_center,
    output logic [17:0] tiles,
    output logic [8:0]  color,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        turn
);

    localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_CYCLES - 1);

    logic w_up, w_down, w_left, w_right, w_center;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .i_clk(clk), .i_reset(reset), .i_btn(btn_up), .o_press(w_up));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .i_clk(clk), .i_reset(reset), .i_btn(btn_down), .o_press(w_down));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .i_clk(clk), .i_reset(reset), .i_btn(btn_left), .o_press(w_left));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .i_clk(clk), .i_reset(reset), .i_btn(btn_right), .o_press(w_right));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_center (
        .i_clk(clk), .i_reset(reset), .i_btn(btn_center), .o_press(w_center));

    state_t            r_state;
    logic [8:0]        r_drawn;
    logic [8:0]        r_shape;
    logic              r_turn;
    logic [1:0]        r_row;
    logic [1:0]        r_col;
    logic [1:0]        r_winner;
    logic [2:0]        r_win_line;
    logic              r_phase;
    logic [BLK_W-1:0]  r_blink_cnt;

    logic [17:0]       r_tiles;
    logic [8:0]        r_color;
    logic [1:0]        r_winner_o;
    logic              r_game_over;
    logic              r_turn_o;

    logic [CELL_W-1:0] w_cell;
    logic              w_cell_occupied;
    logic              w_mark;
    logic [8:0]        w_next_drawn;
    logic [8:0]        w_next_shape;
    logic              w_win;
    logic [2:0]        w_win_line;
    logic              w_move;
    logic [17:0]       w_tiles;
    logic [8:0]        w_color;

    assign w_cell          = {2'b00, r_row} * 4'd3 + {2'b00, r_col};
    assign w_cell_occupied = r_drawn[w_cell];
    assign w_mark          = (r_turn == PLAYER_X);
    // Center has top priority; any direction pulse without center is a move.
    assign w_move          = (r_state == ST_PLAY) & ~w_center
                           & (w_up | w_down | w_left | w_right);

    // Board as it would look after the current player marks the cursor cell.
    always_comb begin
        w_next_drawn         = r_drawn;
        w_next_shape         = r_shape;
        w_next_drawn[w_cell] = 1'b1;
        w_next_shape[w_cell] = w_mark;
    end

    // Find the lowest-index line completed by the mover on the next board.
    always_comb begin
        w_win      = 1'b0;
        w_win_line = '0;
        for (int l = NUM_LINES - 1; l >= 0; l--) begin
            if (line_complete(w_next_drawn, w_next_shape, 3'(l), w_mark)) begin
                w_win      = 1'b1;
                w_win_line = 3'(l);
            end
        end
    end

    // Game FSM: cursor moves and mark placement in PLAY, restart from WIN/DRAW.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_PLAY;
            r_drawn    <= '0;
            r_shape    <= '0;
            r_turn     <= PLAYER_X;
            r_row      <= 2'd1;
            r_col      <= 2'd1;
            r_winner   <= WINNER_NONE;
            r_win_line <= '0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_center) begin
                        if (!w_cell_occupied) begin
                            r_drawn <= w_next_drawn;
                            r_shape <= w_next_shape;
                            r_turn  <= ~r_turn;
                            if (w_win) begin
                                r_state    <= ST_WIN;
                                r_winner   <= (r_turn == PLAYER_X) ? WINNER_X : WINNER_O;
                                r_win_line <= w_win_line;
                            end else if (&w_next_drawn) begin
                                r_state  <= ST_DRAW;
                                r_winner <= WINNER_DRAW;
                            end
                        end
                    end else if (w_up) begin
                        r_row <= (r_row == 2'd0) ? 2'd2 : r_row - 2'd1;
                    end else if (w_down) begin
                        r_row <= (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
                    end else if (w_left) begin
                        r_col <= (r_col == 2'd0) ? 2'd2 : r_col - 2'd1;
                    end else if (w_right) begin
                        r_col <= (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
                    end
                end
                ST_WIN, ST_DRAW: begin
                    if (w_center) begin
                        r_state  <= ST_PLAY;
                        r_drawn  <= '0;
                        r_shape  <= '0;
                        r_turn   <= PLAYER_X;
                        r_row    <= 2'd1;
                        r_col    <= 2'd1;
                        r_winner <= WINNER_NONE;
                    end
                end
                default: r_state <= ST_PLAY;
            endcase
        end
    end

    // Cursor blink: free-running half-period, restarted visible on every move.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_move) begin
            r_phase     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_phase     <= ~r_phase;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
    end

    // Compose the board image: marks, cursor preview in PLAY, winning line in WIN.
    always_comb begin
        w_tiles = '0;
        w_color = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            w_tiles[2*i]   = r_drawn[i];
            w_tiles[2*i+1] = r_drawn[i] & r_shape[i];
        end
        case (r_state)
            ST_PLAY: begin
                if (!w_cell_occupied) begin
                    if (r_phase) begin
                        w_tiles[{w_cell, 1'b0}] = 1'b1;
                        w_tiles[{w_cell, 1'b1}] = w_mark;
                        w_color[w_cell]         = 1'b1;
                    end
                end else begin
                    w_color[w_cell] = r_phase;
                end
            end
            ST_WIN: begin
                for (int k = 0; k < 3; k++) begin
                    w_color[LINES[r_win_line][k]] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Register every output toward the renderer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tiles     <= '0;
            r_color     <= '0;
            r_winner_o  <= WINNER_NONE;
            r_game_over <= 1'b0;
            r_turn_o    <= PLAYER_X;
        end else begin
            r_tiles     <= w_tiles;
            r_color     <= w_color;
            r_winner_o  <= r_winner;
            r_game_over <= (r_state != ST_PLAY);
            r_turn_o    <= r_turn;
        end
    end

    assign tiles     = r_tiles;
    assign color     = r_color;
    assign winner    = r_winner_o;
    assign game_over = r_game_over;
    assign turn      = r_turn_o;

endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller: directed table, hand sequences and randomized
// presses checked every cycle against a game-level reference model.
module tb_board_controller;

    localparam int DEB = 4;
    localparam int BLK = 8;

    localparam logic [4:0] BC = 5'b10000;
    localparam logic [4:0] BU = 5'b01000;
    localparam logic [4:0] BD = 5'b00100;
    localparam logic [4:0] BL = 5'b00010;
    localparam logic [4:0] BR = 5'b00001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic        btn_right = 1'b0, btn_center = 1'b0;
    logic [17:0] tiles;
    logic [8:0]  color;
    logic [1:0]  winner;
    logic        game_over;
    logic        turn;

    board_controller #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_center(btn_center),
        .tiles(tiles), .color(color), .winner(winner),
        .game_over(game_over), .turn(turn));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Reference model: board 0 empty / 1 X / 2 O; state 0 play / 1 win / 2 draw.
    int m_board [9];
    int m_row, m_col, m_turn, m_state, m_winner, m_wline;
    int m_e0, m_p0;
    int pend_edge;
    logic [4:0] pend_mask;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    typedef struct {
        logic [4:0]  btn;
        logic [1:0]  w;
        logic        tn;
        logic        go;
        logic [8:0]  cmask;
        logic [8:0]  cval;
        logic [17:0] tmask;
        logic [17:0] tval;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic m_reset();
        foreach (m_board[i]) m_board[i] = 0;
        m_row = 1; m_col = 1; m_turn = 0; m_state = 0;
        m_winner = 0; m_wline = 0;
        m_e0 = cyc; m_p0 = 0; pend_edge = -1;
    endtask

    function automatic bit owns(input int l, input int p);
        return m_board[lines[l][0]] == p && m_board[lines[l][1]] == p && m_board[lines[l][2]] == p;
    endfunction

    task automatic m_apply(input logic [4:0] m);
        int c, wl, filled;
        c = 3 * m_row + m_col; wl = -1; filled = 0;
        if (m_state == 0) begin
            if (m[4]) begin
                if (m_board[c] == 0) begin
                    m_board[c] = m_turn + 1;
                    for (int l = 7; l >= 0; l--) if (owns(l, m_turn + 1)) wl = l;
                    foreach (m_board[i]) if (m_board[i] != 0) filled++;
                    if (wl >= 0) begin m_state = 1; m_winner = m_turn + 1; m_wline = wl; end
                    else if (filled == 9) begin m_state = 2; m_winner = 3; end
                    m_turn = 1 - m_turn;
                end
            end else if (m[3:0] != 4'd0) begin
                if (m[3]) m_row = (m_row + 2) % 3;
                else if (m[2]) m_row = (m_row + 1) % 3;
                else if (m[1]) m_col = (m_col + 2) % 3;
                else m_col = (m_col + 1) % 3;
                m_e0 = cyc; m_p0 = 1;
            end
        end else if (m[4]) begin
            foreach (m_board[i]) m_board[i] = 0;
            m_row = 1; m_col = 1; m_turn = 0; m_state = 0; m_winner = 0;
        end
    endtask

    task automatic m_image(output logic [17:0] t, output logic [8:0] c);
        int cur, ph;
        t = '0; c = '0;
        cur = 3 * m_row + m_col;
        ph = (m_p0 + (cyc - m_e0) / BLK) % 2;
        for (int i = 0; i < 9; i++) begin
            if (m_board[i] != 0) begin
                t[2*i] = 1'b1;
                t[2*i+1] = (m_board[i] == 1);
            end
        end
        if (m_state == 0) begin
            if (m_board[cur] == 0) begin
                if (ph == 1) begin
                    t[2*cur] = 1'b1; t[2*cur+1] = (m_turn == 0); c[cur] = 1'b1;
                end
            end else c[cur] = (ph == 1);
        end else if (m_state == 1) begin
            for (int k = 0; k < 3; k++) c[lines[m_wline][k]] = 1'b1;
        end
    endtask

    // One clock: predict outputs from the pre-edge model, advance, compare.
    task automatic tick();
        logic [17:0] et; logic [8:0] ec; logic [1:0] ew; logic eg, etn, rst_now;
        m_image(et, ec);
        ew = 2'(m_winner); eg = (m_state != 0); etn = (m_turn == 1);
        rst_now = reset;
        @(posedge clk); cyc++; #1;
        if (rst_now) begin
            m_reset(); et = '0; ec = '0; ew = '0; eg = 1'b0; etn = 1'b0;
        end else if (pend_edge == cyc) begin
            m_apply(pend_mask); pend_edge = -1;
        end
        check("image", {1'b0, tiles, color, winner, game_over, turn}, {1'b0, et, ec, ew, eg, etn});
    endtask

    task automatic drive(input logic [4:0] m);
        btn_center = m[4]; btn_up = m[3]; btn_down = m[2]; btn_left = m[1]; btn_right = m[0];
    endtask

    // Hold buttons for `hold` cycles; returns on the first cycle the action is visible.
    task automatic press(input logic [4:0] m, input int hold);
        int r;
        r = cyc;
        drive(m);
        if (hold >= DEB) begin pend_edge = r + DEB + 2; pend_mask = m; end
        for (int i = 0; i < hold; i++) tick();
        drive(5'b0);
        while (cyc < r + DEB + 3) tick();
    endtask

    function automatic void add(input logic [4:0] b, input logic [1:0] w, input logic tn, input logic go,
                                input logic [8:0] cm, input logic [8:0] cv,
                                input logic [17:0] tm, input logic [17:0] tv);
        vec_t v;
        v.btn = b; v.w = w; v.tn = tn; v.go = go; v.cmask = cm; v.cval = cv; v.tmask = tm; v.tval = tv;
        tbl.push_back(v);
    endfunction

    function automatic void mv(input logic [4:0] b, input int cur, input logic tn);
        add(b, 2'b00, tn, 1'b0, 9'h1FF, 9'(1 << cur), 18'h0, 18'h0);
    endfunction

    function automatic void pl(input logic [4:0] b, input logic tn);
        add(b, 2'b00, tn, 1'b0, 9'h0, 9'h0, 18'h0, 18'h0);
    endfunction

    initial begin
        logic [4:0] m;
        int h, e;
        m_reset();

        // Directed table: wrap, X wins top row, occupied cell, priority, draw, restart.
        mv(BL, 4, 0); mv(BU, 1, 0); mv(BU, 7, 0); mv(BL, 6, 0); mv(BL, 8, 0);
        mv(BD, 2, 0); mv(BL, 1, 0); mv(BL, 0, 0);
        pl(BC, 1); mv(BD, 3, 1); pl(BC, 0); mv(BU, 0, 0); mv(BR, 1, 0);
        pl(BC, 1); mv(BD, 4, 1); pl(BC, 0); mv(BU, 1, 0); mv(BR, 2, 0);
        add(BC, 2'b01, 1, 1, 9'h1FF, 9'h007, 18'h3FFFF, 18'h0017F);
        add(BU, 2'b01, 1, 1, 9'h1FF, 9'h007, 18'h3FFFF, 18'h0017F);
        add(BR, 2'b01, 1, 1, 9'h1FF, 9'h007, 18'h3FFFF, 18'h0017F);
        add(BC, 2'b00, 0, 0, 9'h1EF, 9'h000, 18'h3FCFF, 18'h0);
        mv(BU, 1, 0); mv(BL, 0, 0); pl(BC, 1); pl(BC, 1); mv(BR, 1, 1);
        pl(BC | BU, 0); mv(BR, 2, 0); pl(BC, 1); mv(BD, 5, 1); mv(BL, 4, 1);
        pl(BC, 0); mv(BL, 3, 0); pl(BC, 1); mv(BR, 4, 1); mv(BR, 5, 1);
        pl(BC, 0); mv(BD, 8, 0); mv(BL, 7, 0); pl(BC, 1); mv(BL, 6, 1);
        pl(BC, 0); mv(BR, 7, 0); mv(BR, 8, 0);
        add(BC, 2'b11, 1, 1, 9'h1FF, 9'h000, 18'h3FFFF, 18'b111101010111110111);
        add(BC, 2'b00, 0, 0, 9'h1EF, 9'h000, 18'h3FCFF, 18'h0);
        mv(BR, 5, 0);

        // Reset state and idle blink of the cell-4 preview.
        reset = 1'b1;
        repeat (3) tick();
        check("rst_outputs", {tiles, color, winner, game_over, turn}, 31'h0);
        reset = 1'b0;
        e = cyc;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k >= 9 && k <= 16) begin
                check("blink_on_tiles", tiles, 18'h00300);
                check("blink_on_color", color, 9'h010);
            end else begin
                check("blink_off_tiles", tiles, 18'h0);
                check("blink_off_color", color, 9'h0);
            end
        end
        check("idle_status", {winner, game_over, turn}, 4'h0);

        // Bounce rejection, then a clean press of right.
        drive(BR);
        repeat (3) tick();
        drive(5'b0);
        repeat (10) begin
            tick();
            check("glitch_nomove", color & 9'h1EF, 9'h0);
        end
        press(BR, 5);
        check("right_preview_tiles", tiles[11:10], 2'b11);
        check("right_preview_color", color, 9'h020);
        repeat (4) tick();

        foreach (tbl[i]) begin
            press(tbl[i].btn, 5);
            check($sformatf("tbl%0d_winner", i), winner, tbl[i].w);
            check($sformatf("tbl%0d_turn", i), turn, tbl[i].tn);
            check($sformatf("tbl%0d_over", i), game_over, tbl[i].go);
            if (tbl[i].cmask != 9'h0) check($sformatf("tbl%0d_color", i), color & tbl[i].cmask, tbl[i].cval);
            if (tbl[i].tmask != 18'h0) check($sformatf("tbl%0d_tiles", i), tiles & tbl[i].tmask, tbl[i].tval);
            repeat (4) tick();
        end

        // Reset in the middle of a debounce.
        drive(BD);
        repeat (2) tick();
        drive(5'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (12) tick();
        check("mid_debounce_reset", {winner, game_over, turn}, 4'h0);

        // Randomized presses, glitches, multi-button and occasional resets.
        for (int n = 0; n < 160; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: m = BC;
                4:          m = 5'($urandom_range(1, 31));
                default:    m = 5'(1 << $urandom_range(0, 3));
            endcase
            h = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 6);
            press(m, h);
            repeat ($urandom_range(4, 8)) tick();
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/board_controller.md
# board_controller

Input side of the tic-tac-toe display path: turns five raw push-buttons into the `tiles[17:0]` / `color[8:0]` board image that the VGA tile renderer draws. Debounces buttons, moves a cursor over the 3×3 grid, places alternating X/O marks, detects win/draw, and drives a blinking cursor preview. Sits between the board I/O pins and the tile renderer; all outputs are registered.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a button level.
- `BLINK_CYCLES`, 25_000_000: cycles per half-period of the cursor blink.
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_center` in 1 each: raw button levels, already synchronized to `clk`.
- `tiles` out 18: per cell i (0..8, row-major), `[2i]` = drawn, `[2i+1]` = shape (1 square = X, 0 plus = O).
- `color` out 9: per cell, 1 = red, 0 = white.
- `winner` out 2: 00 none, 01 X, 10 O, 11 draw.
- `game_over` out 1: high in WIN or DRAW.
- `turn` out 1: player to move, 0 = X, 1 = O.

## Operation
- Debounce per button: counter resets on any change of raw vs. accepted level; accepted level updates when the counter reaches `DEBOUNCE_CYCLES`. A rising edge of the accepted level gives a one-cycle press pulse.
- Same-cycle pulses: only one acts, priority center > up > down > left > right. Lower-priority pulses are dropped.
- Cursor: row/col 0..2, cell = 3·row+col. Reset value is row 1, col 1 (cell 4). Moves wrap: up from row 0 goes to row 2, right from col 2 goes to col 0, and so on. Moves are accepted only in PLAY.
- FSM states: PLAY, WIN, DRAW. Reset enters PLAY with board cleared and turn = X.
- PLAY, center on an empty cell:
  - Mark the cell with `turn` and toggle `turn`.
  - Check all 8 lines on the next-board value.
  - Line complete → WIN, winner = mover. Otherwise all 9 occupied → DRAW. Win takes precedence over draw on the 9th move.
- PLAY, center on an occupied cell: no effect.
- WIN/DRAW, center: clear board, turn = X, cursor = 4, enter PLAY. Direction buttons are ignored.
- Blink phase toggles every `BLINK_CYCLES`. Any accepted cursor move forces phase = 1 and counter = 0.
- Output image in PLAY:
  - Occupied cells: drawn with their shape, color 0.
  - Cursor on an empty cell: when phase = 1, drawn as the current player's shape with color 1; when phase = 0, blank.
  - Cursor on an occupied cell: color bit = phase.
- Output image in WIN: every mark drawn; winning-line cells color 1, all others 0; no cursor preview. If several lines complete at once, the lowest line index in the package order is highlighted.
- Output image in DRAW: every mark drawn, color all 0, no preview.

## Timing
- Reset values: tiles 0, color 0, winner 00, game_over 0, turn 0.
- Internal reset values: cursor 4, blink phase 0, counter 0, debounce levels 0.
- Press pulse occurs 1 cycle after the accepted level changes, which takes `DEBOUNCE_CYCLES` stable cycles.
- Pulse in cycle N:
  - Board, FSM and cursor update at edge N+1.
  - `tiles`, `color`, `winner`, `game_over` and `turn` reflect the change after edge N+2.
- Reset asserted mid-debounce or mid-game: all state returns to reset values on the next edge. Held buttons must be released and re-pressed to act.

## Structure
- Package `tt_pkg` holds:
  - State enum (PLAY/WIN/DRAW).
  - Player and winner encodings.
  - Cell-index width.
  - `LINES` constant: 8 triples of cell indices, ordered rows 0-2, cols 0-2, diagonal 0-4-8, anti-diagonal 2-4-6.
- Sub-module `button_debounce`, parameterized by `DEBOUNCE_CYCLES`, output is the press pulse. Instantiated five times.

## Test plan
Bench runs with `DEBOUNCE_CYCLES`=4 and `BLINK_CYCLES`=8.
- **Reset state:** reset, then idle 20 cycles → tiles 0, winner 00, turn 0; cell 4 alternates tiles[9:8]=2'b11/color[4]=1 and blank every 8 cycles.
- **Bounce rejection:** btn_right glitches high for 3 cycles then low → no cursor move. Held 5+ cycles → cursor cell 5, preview at cell 5 within 2 cycles of the pulse.
- **Wrap:** cursor at 4; press up twice → cursor row wraps to 2, cell 7. Press left twice → cell 6 → cell 8.
- **X wins top row:** X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 → winner 01, game_over 1, color = 9'b000000111, tiles[5:0]=6'b111111. Further direction presses change nothing.
- **Occupied cell and priority:** center on occupied cell 0 → tiles and turn unchanged. Center+up in the same cycle on empty cell 1 → mark placed, cursor unmoved.
- **Draw then restart:** sequence X0,O1,X2,O4,X3,O5,X7,O6,X8 → winner 11, color 0. Center → tiles 0, turn 0, game_over 0, cursor 4.
